cr_seu_randclk: RTL and testbench

CR_SEU_RANDCLK -- requirements
Module: cr_seu_randclk

---
 rtl/cr_seu_randclk_pkg.sv | 12 +
 rtl/cr_seu_randclk_lfsr.sv | 50 +++++
 rtl/cr_seu_randclk.sv | 88 ++++++++
 tb/tb_cr_seu_randclk.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cr_seu_randclk_pkg.sv
// cr_seu_randclk_pkg
//   Shared constants for the random-clock mod-enable generator.
//   RANDCLK_W_DEF    : default width of the LFSR and the mod-enable bus
//   RANDCLK_TAPS     : Galois feedback mask applied when the LFSR shifts out a 1
//   RANDCLK_SEED_RST : reset value, also used in place of an all-zero seed
package cr_seu_randclk_pkg;

  localparam int          RANDCLK_W_DEF    = 32;
  localparam logic [31:0] RANDCLK_TAPS     = 32'h80200003;
  localparam logic [31:0] RANDCLK_SEED_RST = 32'h00000001;

endpackage

// File: rtl/cr_seu_randclk_lfsr.sv
// cr_seu_randclk_lfsr
//   LFSR state register with seed-load mux, zero-seed substitution and
//   Galois next-state logic.
// Ports:
//   clk       : block clock
//   rst       : asynchronous active-high reset (state -> RANDCLK_SEED_RST)
//   step      : advance the LFSR one position this cycle
//   seed_vld  : load seed this cycle (takes priority over step)
//   seed      : seed value
//   state     : current LFSR register value
//   state_nxt : value the register takes at the next edge
//   seed_zero : seed input is all zeros
module cr_seu_randclk_lfsr
  import cr_seu_randclk_pkg::*;
#(
  parameter int W = RANDCLK_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         seed_vld,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state,
  output logic [W-1:0] state_nxt,
  output logic         seed_zero
);

  localparam logic [W-1:0] TAPS_W     = W'(RANDCLK_TAPS);
  localparam logic [W-1:0] SEED_RST_W = W'(RANDCLK_SEED_RST);

  always_comb begin
    seed_zero = (seed == '0);
    state_nxt = state;
    if (seed_vld) begin
      // An all-zero state would lock the LFSR, so substitute the reset seed.
      state_nxt = seed_zero ? SEED_RST_W : seed;
    end else if (step) begin
      state_nxt = (state >> 1) ^ (state[0] ? TAPS_W : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_RST_W;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/cr_seu_randclk.sv
// cr_seu_randclk
//   Random clock mod-enable generator. An LFSR advances once every
//   (cp0_seu_interval + 1) enabled cycles; its post-update value, gated by
//   the enable and scan mode, is registered onto the mod-enable bus.
// Ports:
//   forever_cpuclk         : block clock
//   cpurst                 : asynchronous active-high reset
//   cp0_seu_randclk_en     : global enable (level)
//   cp0_seu_seed_vld       : one-cycle seed load strobe
//   cp0_seu_seed           : seed value
//   cp0_seu_interval       : LFSR step period minus one
//   pad_yy_scan_mode       : forces mod-enables low
//   seu_lsu_randclk_mod_en : registered mod-enable bus
//   seu_randclk_seed_err   : sticky, last loaded seed was zero
module cr_seu_randclk
  import cr_seu_randclk_pkg::*;
#(
  parameter int RANDCLK_W = RANDCLK_W_DEF
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 cp0_seu_randclk_en,
  input  logic                 cp0_seu_seed_vld,
  input  logic [RANDCLK_W-1:0] cp0_seu_seed,
  input  logic [3:0]           cp0_seu_interval,
  input  logic                 pad_yy_scan_mode,
  output logic [RANDCLK_W-1:0] seu_lsu_randclk_mod_en,
  output logic                 seu_randclk_seed_err
);

  logic [3:0]           cnt_q;
  logic                 cnt_hit;
  logic                 step;
  logic                 seed_zero;
  logic [RANDCLK_W-1:0] lfsr_q;
  logic [RANDCLK_W-1:0] lfsr_nxt;

  // ">=" rather than "==" so a lowered interval fires on the next cycle
  // instead of letting the counter run on; the counter therefore never
  // exceeds 15 because any interval value is <= 15.
  assign cnt_hit = (cnt_q >= cp0_seu_interval);
  // A seed load replaces the step that would otherwise happen this cycle.
  assign step    = cp0_seu_randclk_en & cnt_hit & ~cp0_seu_seed_vld;

  cr_seu_randclk_lfsr #(
    .W (RANDCLK_W)
  ) u_lfsr (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .step      (step),
    .seed_vld  (cp0_seu_seed_vld),
    .seed      (cp0_seu_seed),
    .state     (lfsr_q),
    .state_nxt (lfsr_nxt),
    .seed_zero (seed_zero)
  );

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_q <= 4'd0;
    end else if (cp0_seu_seed_vld || !cp0_seu_randclk_en || cnt_hit) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // The bus shows the LFSR value after this cycle's update, so a step,
  // seed load or enable change appears exactly one cycle later.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      seu_lsu_randclk_mod_en <= '0;
    end else begin
      seu_lsu_randclk_mod_en <= lfsr_nxt &
                                {RANDCLK_W{cp0_seu_randclk_en & ~pad_yy_scan_mode}};
    end
  end

  // Sticky: only a later non-zero seed load clears it.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      seu_randclk_seed_err <= 1'b0;
    end else if (cp0_seu_seed_vld) begin
      seu_randclk_seed_err <= seed_zero;
    end
  end

endmodule

// File: tb/tb_cr_seu_randclk.sv
// tb_cr_seu_randclk
//   Directed bench for cr_seu_randclk with hand-computed LFSR sequences.
module tb_cr_seu_randclk;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         en;
  logic         seed_vld;
  logic [W-1:0] seed;
  logic [3:0]   interval;
  logic         scan;
  logic [W-1:0] mod_en;
  logic         seed_err;

  int checks   = 0;
  int failures = 0;

  cr_seu_randclk #(.RANDCLK_W(W)) dut (
    .forever_cpuclk         (clk),
    .cpurst                 (rst),
    .cp0_seu_randclk_en     (en),
    .cp0_seu_seed_vld       (seed_vld),
    .cp0_seu_seed           (seed),
    .cp0_seu_interval       (interval),
    .pad_yy_scan_mode       (scan),
    .seu_lsu_randclk_mod_en (mod_en),
    .seu_randclk_seed_err   (seed_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Driver: advance one clock, land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected mod_en for 8 cycles at interval=3 starting from LFSR 60180001.
  logic [W-1:0] intv_exp [8];

  initial begin
    intv_exp = '{32'h60180001, 32'h60180001, 32'h60180001, 32'hB02C0003,
                 32'hB02C0003, 32'hB02C0003, 32'hB02C0003, 32'hD8360002};

    rst = 1'b1; en = 1'b0; seed_vld = 1'b0; seed = '0; interval = 4'd0; scan = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_mod_en",   mod_en, '0);
    check("rst_seed_err", {31'd0, seed_err}, '0);
    check("rst_lfsr",     dut.lfsr_q, 32'h00000001);
    check("rst_cnt",      {28'd0, dut.cnt_q}, '0);
    rst = 1'b0;

    // Stepping every cycle
    en = 1'b1;
    tick(); check("step0", mod_en, 32'h80200003);
    tick(); check("step1", mod_en, 32'hC0300002);
    tick(); check("step2", mod_en, 32'h60180001);

    // Interval of 4 cycles
    interval = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("intv%0d", i), mod_en, intv_exp[i]);
    end
    check("intv_cnt", {28'd0, dut.cnt_q}, '0);

    // Seed load in a cycle where a step is due
    repeat (3) tick();
    check("pre_seed_cnt", {28'd0, dut.cnt_q}, 32'd3);
    seed_vld = 1'b1; seed = 32'h12345678;
    tick();
    seed_vld = 1'b0;
    check("seed_mod_en", mod_en, 32'h12345678);
    check("seed_cnt",    {28'd0, dut.cnt_q}, '0);

    // Lowering the interval mid-count steps on the next cycle
    repeat (2) tick();
    check("mid_hold", mod_en, 32'h12345678);
    interval = 4'd0;
    tick();
    check("lower_intv", mod_en, 32'h091A2B3C);

    // Zero seed substitution and sticky error
    seed_vld = 1'b1; seed = '0;
    tick();
    seed_vld = 1'b0;
    check("zero_lfsr",   dut.lfsr_q, 32'h00000001);
    check("zero_mod_en", mod_en, 32'h00000001);
    check("zero_err",    {31'd0, seed_err}, 32'd1);
    tick();
    check("zero_step",   mod_en, 32'h80200003);
    check("err_sticky",  {31'd0, seed_err}, 32'd1);
    seed_vld = 1'b1; seed = 32'h5;
    tick();
    seed_vld = 1'b0;
    check("seed5_mod_en", mod_en, 32'h00000005);
    check("seed5_err",    {31'd0, seed_err}, '0);

    // Scan gating: output forced low, LFSR keeps stepping
    tick(); check("pre_scan", mod_en, 32'h80200001);
    scan = 1'b1;
    tick();
    check("scan_mod_en", mod_en, '0);
    check("scan_lfsr",   dut.lfsr_q, 32'hC0300003);
    scan = 1'b0;
    tick(); check("post_scan", mod_en, 32'hE0380002);

    // Enable gating: output low, LFSR held, counter cleared
    en = 1'b0;
    tick();
    check("dis_mod_en", mod_en, '0);
    check("dis_lfsr",   dut.lfsr_q, 32'hE0380002);
    tick();
    check("dis_hold",   dut.lfsr_q, 32'hE0380002);
    check("dis_cnt",    {28'd0, dut.cnt_q}, '0);
    en = 1'b1;
    tick(); check("reen", mod_en, 32'h701C0001);

    // Asynchronous reset mid-count, then restart
    interval = 4'd3;
    seed_vld = 1'b1; seed = '0;
    tick();
    seed_vld = 1'b0;
    repeat (2) tick();
    check("pre_rst_cnt", {28'd0, dut.cnt_q}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_lfsr",   dut.lfsr_q, 32'h00000001);
    check("arst_cnt",    {28'd0, dut.cnt_q}, '0);
    check("arst_mod_en", mod_en, '0);
    check("arst_err",    {31'd0, seed_err}, '0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_mod_en", mod_en, 32'h00000001);
    check("post_rst_cnt",    {28'd0, dut.cnt_q}, 32'd1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
